// File: rtl/lcd_text_driver.sv
// HD44780 16x2 text driver: powers up and initialises the LCD in 8-bit write-only mode,
// then mirrors the calculator's 32-character text buffer onto the two display lines.
module lcd_text_driver #(
   parameter int POWERUP_CYC  = 750000,
   parameter int SETUP_CYC    = 3,
   parameter int E_HIGH_CYC   = 12,
   parameter int CMD_WAIT_CYC = 2000,
   parameter int CLR_WAIT_CYC = 82000
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [255:0] text_in,
   input  logic         refresh_req,
   output logic [7:0]   lcd_data,
   output logic         lcd_rs,
   output logic         lcd_rw,
   output logic         lcd_e,
   output logic         init_done,
   output logic         busy
);

   typedef enum logic [1:0] {POWERUP, INIT, IDLE, REFRESH} state_t;
   typedef enum logic [1:0] {SETUP, EHIGH, WAIT} phase_t;

   localparam int MAX_A   = (POWERUP_CYC > CLR_WAIT_CYC) ? POWERUP_CYC : CLR_WAIT_CYC;
   localparam int MAX_B   = (CMD_WAIT_CYC > E_HIGH_CYC) ? CMD_WAIT_CYC : E_HIGH_CYC;
   localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_CYC = (MAX_C > SETUP_CYC) ? MAX_C : SETUP_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYC - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] EHIGH_LAST = CNT_W'(E_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);
   localparam logic [5:0]       INIT_LAST  = 6'd6;
   localparam logic [5:0]       REF_LAST   = 6'd33;

   state_t             state, state_next;
   phase_t             phase, phase_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic [5:0]         step, step_next;
   logic [255:0]       shadow, shadow_next;
   logic               init_done_next;
   logic [7:0]         lcd_data_next;
   logic               lcd_rs_next;
   logic [8:0]         nxt_word;
   logic               cur_clr;
   logic [CNT_W-1:0]   wait_last;

   // Returns {rs, byte} for one write: init commands, or the refresh burst
   // (80, chars 0..15, C0, chars 16..31) with control codes shown as blanks.
   function automatic logic [8:0] write_word(input logic in_init, input logic [5:0] idx,
                                             input logic [255:0] txt);
      logic [4:0] ci;
      logic [7:0] ch;
      int         pos;
      write_word = {1'b0, 8'h06};
      ci         = '0;
      ch         = '0;
      pos        = 0;
      if (in_init) begin
         case (idx)
            6'd0, 6'd1, 6'd2, 6'd3: write_word = {1'b0, 8'h38};
            6'd4:                   write_word = {1'b0, 8'h0C};
            6'd5:                   write_word = {1'b0, 8'h01};
            default:                write_word = {1'b0, 8'h06};
         endcase
      end else if (idx == 6'd0) begin
         write_word = {1'b0, 8'h80};
      end else if (idx == 6'd17) begin
         write_word = {1'b0, 8'hC0};
      end else begin
         ci  = (idx < 6'd17) ? 5'(idx - 6'd1) : 5'(idx - 6'd2);
         pos = 8 * (31 - int'(ci));
         ch  = txt[pos +: 8];
         if (ch < 8'h20 || ch == 8'h7F) ch = 8'h20;
         write_word = {1'b1, ch};
      end
   endfunction

   // Clear and the three power-on function-sets need the long settling wait.
   function automatic logic is_clr_step(input logic in_init, input logic [5:0] idx);
      is_clr_step = in_init && (idx == 6'd0 || idx == 6'd1 || idx == 6'd2 || idx == 6'd5);
   endfunction

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= POWERUP;
         phase     <= SETUP;
         cnt       <= '0;
         step      <= '0;
         shadow    <= {32{8'h20}};
         init_done <= 1'b0;
         lcd_data  <= 8'h00;
         lcd_rs    <= 1'b0;
      end else begin
         state     <= state_next;
         phase     <= phase_next;
         cnt       <= cnt_next;
         step      <= step_next;
         shadow    <= shadow_next;
         init_done <= init_done_next;
         lcd_data  <= lcd_data_next;
         lcd_rs    <= lcd_rs_next;
      end
   end

   assign nxt_word  = write_word(state == INIT, step + 6'd1, shadow);
   assign cur_clr   = is_clr_step(state == INIT, step);
   assign wait_last = cur_clr ? CLR_LAST : CMD_LAST;

   // Each write walks SETUP -> EHIGH -> WAIT; data/rs are latched only on SETUP entry.
   always_comb begin
      state_next     = state;
      phase_next     = phase;
      cnt_next       = cnt;
      step_next      = step;
      shadow_next    = shadow;
      init_done_next = init_done;
      lcd_data_next  = lcd_data;
      lcd_rs_next    = lcd_rs;
      case (state)
         POWERUP: begin
            if (cnt == PWR_LAST) begin
               state_next    = INIT;
               phase_next    = SETUP;
               cnt_next      = '0;
               step_next     = '0;
               lcd_rs_next   = 1'b0;
               lcd_data_next = 8'h38;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         IDLE: begin
            if (text_in != shadow || refresh_req) begin
               shadow_next   = text_in;
               state_next    = REFRESH;
               phase_next    = SETUP;
               cnt_next      = '0;
               step_next     = '0;
               lcd_rs_next   = 1'b0;
               lcd_data_next = 8'h80;
            end
         end
         default: begin
            case (phase)
               SETUP: begin
                  if (cnt == SETUP_LAST) begin
                     phase_next = EHIGH;
                     cnt_next   = '0;
                  end else begin
                     cnt_next = cnt + 1'b1;
                  end
               end
               EHIGH: begin
                  if (cnt == EHIGH_LAST) begin
                     phase_next = WAIT;
                     cnt_next   = '0;
                  end else begin
                     cnt_next = cnt + 1'b1;
                  end
               end
               default: begin
                  if (cnt != wait_last) begin
                     cnt_next = cnt + 1'b1;
                  end else begin
                     cnt_next = '0;
                     if (state == INIT && step == INIT_LAST) begin
                        init_done_next = 1'b1;
                        shadow_next    = {32{8'h20}};
                        state_next     = REFRESH;
                        phase_next     = SETUP;
                        step_next      = '0;
                        lcd_rs_next    = 1'b0;
                        lcd_data_next  = 8'h80;
                     end else if (state == REFRESH && step == REF_LAST) begin
                        state_next = IDLE;
                        phase_next = SETUP;
                        step_next  = '0;
                     end else begin
                        phase_next    = SETUP;
                        step_next     = step + 6'd1;
                        lcd_rs_next   = nxt_word[8];
                        lcd_data_next = nxt_word[7:0];
                     end
                  end
               end
            endcase
         end
      endcase
   end

   // E is decoded straight from state so an async reset drops it in the same cycle.
   always_comb begin
      lcd_e  = (state == INIT || state == REFRESH) && (phase == EHIGH);
      busy   = (state != IDLE);
      lcd_rw = 1'b0;
   end

endmodule

// File: tb/tb_lcd_text_driver.sv
// Directed self-checking bench for lcd_text_driver using short timing parameters;
// a monitor captures every E-strobed write so bursts can be compared against expected bytes.
module tb_lcd_text_driver;

   logic         Clk = 1'b0;
   logic         Reset;
   logic [255:0] text_in;
   logic         refresh_req;
   logic [7:0]   lcd_data;
   logic         lcd_rs;
   logic         lcd_rw;
   logic         lcd_e;
   logic         init_done;
   logic         busy;

   int           test_count = 0;
   int           fail_count = 0;
   int           cyc = 0;
   int           last_rise_cyc = 0;
   int           e_len = 0;
   int           min_e = 1000;
   int           max_e = 0;
   logic         prev_e = 1'b0;
   logic [8:0]   cap_q[$];

   logic [255:0] txt_blank = {32{8'h20}};
   logic [255:0] txt_a     = "*Add Sub Div Mlt GCD isPrme Sqrt";
   logic [255:0] txt_c     = "0123456789ABCDEFghijklmnopqrstuv";
   logic [255:0] txt_b;
   logic [7:0]   init_list [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

   lcd_text_driver #(
      .POWERUP_CYC(20), .SETUP_CYC(1), .E_HIGH_CYC(2), .CMD_WAIT_CYC(4), .CLR_WAIT_CYC(10)
   ) dut (
      .Clk(Clk), .Reset(Reset), .text_in(text_in), .refresh_req(refresh_req),
      .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
      .init_done(init_done), .busy(busy)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   // Records {rs,data} at each E rise and tracks E pulse widths.
   always @(negedge Clk) begin
      if (Reset) begin
         prev_e = 1'b0;
         e_len  = 0;
      end else begin
         if (lcd_e && !prev_e) begin
            cap_q.push_back({lcd_rs, lcd_data});
            last_rise_cyc = cyc;
         end
         if (lcd_e) begin
            e_len++;
         end else if (prev_e) begin
            if (e_len < min_e) min_e = e_len;
            if (e_len > max_e) max_e = e_len;
            e_len = 0;
         end
         prev_e = lcd_e;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      test_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [255:0] txt, input logic req);
      @(negedge Clk);
      text_in     = txt;
      refresh_req = req;
      @(negedge Clk);
      refresh_req = 1'b0;
   endtask

   task automatic wait_idle(input string tag, output int fall_cyc);
      bit done = 0;
      fall_cyc = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(posedge Clk);
         #1;
         if (!busy) begin
            done     = 1;
            fall_cyc = cyc;
         end
      end
      if (!done) checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic wait_writes(input string tag, input int n, input bit need_idle);
      bit done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge Clk);
         if (cap_q.size() >= n && (!need_idle || !busy)) done = 1;
      end
      if (!done) checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   function automatic logic [8:0] exp_write(input logic [255:0] txt, input int k);
      int         ci;
      logic [7:0] ch;
      if (k == 0)  return {1'b0, 8'h80};
      if (k == 17) return {1'b0, 8'hC0};
      ci = (k < 17) ? k - 1 : k - 2;
      ch = txt[8*(31-ci) +: 8];
      if (ch < 8'h20 || ch == 8'h7F) ch = 8'h20;
      return {1'b1, ch};
   endfunction

   task automatic check_burst(input string tag, input int base, input logic [255:0] txt);
      logic [31:0] obs;
      for (int k = 0; k < 34; k++) begin
         obs = (base + k < cap_q.size()) ? {23'd0, cap_q[base+k]} : 32'hFFFF_FFFF;
         checkOutput($sformatf("%s_w%0d", tag, k), obs, {23'd0, exp_write(txt, k)});
      end
   endtask

   task automatic check_init_list(input string tag);
      logic [31:0] obs;
      for (int k = 0; k < 7; k++) begin
         obs = (k < cap_q.size()) ? {23'd0, cap_q[k]} : 32'hFFFF_FFFF;
         checkOutput($sformatf("%s_%0d", tag, k), obs, {24'd0, init_list[k]});
      end
   endtask

   task automatic check_first_rise(input string tag);
      int rise_at = 0;
      for (int c = 1; c <= 100 && rise_at == 0; c++) begin
         @(posedge Clk);
         #1;
         if (lcd_e) rise_at = c;
      end
      checkOutput({tag, "_cycle"}, rise_at, 32'd21);
      checkOutput({tag, "_data"}, {24'd0, lcd_data}, 32'h38);
      checkOutput({tag, "_rs"}, {31'd0, lcd_rs}, 32'd0);
      checkOutput({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
   endtask

   initial begin
      int fall_cyc;
      txt_b = txt_a;
      txt_b[255-8*3 -: 8]  = 8'h00;
      txt_b[255-8*20 -: 8] = 8'h7F;
      txt_b[7:0]           = 8'hA5;

      Reset       = 1'b1;
      text_in     = txt_blank;
      refresh_req = 1'b0;
      repeat (3) @(negedge Clk);
      checkOutput("rst_data", {24'd0, lcd_data}, 32'h00);
      checkOutput("rst_rs", {31'd0, lcd_rs}, 32'd0);
      checkOutput("rst_rw", {31'd0, lcd_rw}, 32'd0);
      checkOutput("rst_e", {31'd0, lcd_e}, 32'd0);
      checkOutput("rst_init_done", {31'd0, init_done}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd1);

      // Power-up, init list and the initial blank refresh.
      Reset = 1'b0;
      cap_q.delete();
      check_first_rise("first_rise");
      wait_idle("init", fall_cyc);
      check_init_list("init");
      check_burst("blank", 7, txt_blank);
      checkOutput("init_writes", cap_q.size(), 32'd41);
      checkOutput("init_done_set", {31'd0, init_done}, 32'd1);

      // Text change triggers one refresh burst.
      cap_q.delete();
      applyStimulus(txt_a, 1'b0);
      wait_idle("text", fall_cyc);
      checkOutput("text_writes", cap_q.size(), 32'd34);
      check_burst("text", 0, txt_a);
      checkOutput("busy_fall_gap", fall_cyc - last_rise_cyc, 32'd6);

      // Forced refresh in IDLE; second pulse during REFRESH is dropped.
      cap_q.delete();
      applyStimulus(txt_a, 1'b1);
      wait_writes("req_mid", 3, 1'b0);
      applyStimulus(txt_a, 1'b1);
      wait_idle("req", fall_cyc);
      repeat (60) @(negedge Clk);
      checkOutput("req_busy", {31'd0, busy}, 32'd0);
      checkOutput("req_writes", cap_q.size(), 32'd34);
      check_burst("req", 0, txt_a);

      // Text change at char-write #5: old burst completes, then one burst of new text.
      cap_q.delete();
      applyStimulus(txt_c, 1'b0);
      wait_writes("chg_mid", 6, 1'b0);
      applyStimulus(txt_b, 1'b0);
      wait_writes("chg", 68, 1'b1);
      repeat (60) @(negedge Clk);
      checkOutput("chg_writes", cap_q.size(), 32'd68);
      check_burst("chg_old", 0, txt_c);
      check_burst("chg_new", 34, txt_b);
      if (cap_q.size() >= 68) begin
         checkOutput("ctrl_char3", {23'd0, cap_q[34+4]}, 32'h120);
         checkOutput("del_char20", {23'd0, cap_q[34+22]}, 32'h120);
         checkOutput("hi_char31", {23'd0, cap_q[34+33]}, 32'h1A5);
      end else begin
         checkOutput("sanitize_missing", cap_q.size(), 32'd68);
      end

      // Reset while E is high mid-refresh restarts power-up and init.
      applyStimulus(txt_a, 1'b1);
      begin
         bit seen = 0;
         for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge Clk);
            #1;
            if (lcd_e) seen = 1;
         end
         checkOutput("mid_e_seen", {31'd0, seen}, 32'd1);
      end
      #1 Reset = 1'b1;
      #1;
      checkOutput("mid_rst_e", {31'd0, lcd_e}, 32'd0);
      checkOutput("mid_rst_init_done", {31'd0, init_done}, 32'd0);
      checkOutput("mid_rst_busy", {31'd0, busy}, 32'd1);
      repeat (2) @(negedge Clk);
      cap_q.delete();
      Reset = 1'b0;
      check_first_rise("re_rise");
      wait_idle("re_init", fall_cyc);
      check_init_list("re_init");
      checkOutput("re_init_done", {31'd0, init_done}, 32'd1);

      checkOutput("e_high_min", min_e, 32'd2);
      checkOutput("e_high_max", max_e, 32'd2);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
